mem_responder: RTL



---
 rtl/mem_responder_pkg.sv | 16 +
 rtl/ram_sync.sv | 23 ++
 rtl/mem_responder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the processor-bus memory responder: region codes
// decoded from ADDR[15:12] and the write-strobe qualifier state encoding.
package mem_responder_pkg;

  localparam logic [3:0] REG_RAM   = 4'h0;
  localparam logic [3:0] REG_LED   = 4'h1;
  localparam logic [3:0] REG_SW    = 4'h2;
  localparam logic [3:0] REG_TIMER = 4'h3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HOLD = 2'd2
  } wr_state_e;

endpackage

// File: rtl/ram_sync.sv
// Single-port word RAM with synchronous read (read-before-write on a shared
// address). Contents are not initialised.
module ram_sync #(
  parameter int    DW        = 16,
  parameter int    AW        = 7,
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Old contents are returned when reading and writing the same word.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the 16-bit processor bus: RAM, LED register,
// synchronised switches and a loadable free-running timer behind a 2-stage read path.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int    RAM_AW    = 7,
  parameter int    LED_W     = 10,
  parameter int    SW_W      = 10,
  parameter string INIT_FILE = ""
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [15:0]      ADDR,
  input  logic [15:0]      DOUT,
  input  logic             W,
  output logic [15:0]      DIN,
  input  logic [SW_W-1:0]  SW,
  output logic [LED_W-1:0] LEDR
);

  wr_state_e         state;
  wr_state_e         state_next;
  logic              wr_en;
  logic              ram_we;
  logic              led_we;
  logic              timer_we;
  logic [15:0]       addr_q;
  logic [RAM_AW-1:0] ram_addr;
  logic [15:0]       ram_rdata;
  logic [SW_W-1:0]   sw_meta;
  logic [SW_W-1:0]   sw_sync;
  logic [15:0]       timer;
  logic [LED_W-1:0]  led;
  logic [15:0]       led_ext;
  logic [15:0]       sw_ext;
  logic [15:0]       io_rdata;
  logic [15:0]       din_io;
  logic              sel_ram_q;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{addr_q[11:RAM_AW], ADDR[11:RAM_AW]};
  assign LEDR = led;

  // Reset lands in HOLD so a strobe already high at release is never committed.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= HOLD;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (W) state_next = ARM;
      ARM:     state_next = W ? HOLD : IDLE;
      HOLD:    if (!W) state_next = IDLE;
      default: state_next = HOLD;
    endcase
  end

  always_comb begin
    wr_en = (state == ARM) && W;
  end

  always_comb begin
    ram_we   = wr_en && (ADDR[15:12] == REG_RAM);
    led_we   = wr_en && (ADDR[15:12] == REG_LED);
    timer_we = wr_en && (ADDR[15:12] == REG_TIMER);
  end

  // ADDR is stable across a commit, so sharing the port with the read address is safe.
  assign ram_addr = ram_we ? ADDR[RAM_AW-1:0] : addr_q[RAM_AW-1:0];

  ram_sync #(
    .DW        (16),
    .AW        (RAM_AW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (Clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (DOUT),
    .rdata (ram_rdata)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      led     <= '0;
      timer   <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
      addr_q  <= '0;
    end else begin
      if (led_we) led <= DOUT[LED_W-1:0];
      timer   <= timer_we ? DOUT : timer + 16'd1;
      sw_meta <= SW;
      sw_sync <= sw_meta;
      addr_q  <= ADDR;
    end
  end

  always_comb begin
    led_ext = '0;
    led_ext[LED_W-1:0] = led;
    sw_ext = '0;
    sw_ext[SW_W-1:0] = sw_sync;
    io_rdata = '0;
    case (addr_q[15:12])
      REG_LED:   io_rdata = led_ext;
      REG_SW:    io_rdata = sw_ext;
      REG_TIMER: io_rdata = timer;
      default:   io_rdata = '0;
    endcase
  end

  // Stage 2: RAM data comes from the RAM's own register, everything else from din_io.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      din_io    <= '0;
      sel_ram_q <= 1'b0;
    end else begin
      din_io    <= io_rdata;
      sel_ram_q <= (addr_q[15:12] == REG_RAM);
    end
  end

  assign DIN = sel_ram_q ? ram_rdata : din_io;

endmodule
